// File: rtl/pid_chn_scheduler.sv
// Frame scheduler for the shared PID core: snapshots channel words once per PERIOD, issues one
// valid/ready beat per enabled channel and tracks results until all return or the frame times out.
module pid_chn_scheduler #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CHN    = 4,
    parameter int unsigned CHN_WIDTH  = 3,
    parameter int unsigned PERIOD     = 50000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en_i,
    input  logic [NUM_CHN-1:0]            chn_mask_i,
    input  logic                          ovr_clr_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] fdb_bus_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] ref_bus_i,
    output logic                          data_valid_o,
    output logic [CHN_WIDTH-1:0]          data_chn_o,
    output logic [DATA_WIDTH-1:0]         data_fdb_o,
    output logic [DATA_WIDTH-1:0]         data_ref_o,
    input  logic                          tready_i,
    input  logic                          res_valid_i,
    input  logic [CHN_WIDTH-1:0]          res_chn_i,
    output logic                          frame_start_o,
    output logic                          frame_done_o,
    output logic                          timeout_o,
    output logic                          overrun_o,
    output logic                          busy_o
);

    localparam int unsigned PW = $clog2(PERIOD);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                        state;
    logic [PW-1:0]                 period_cnt;
    logic [TW-1:0]                 tmo_cnt;
    logic [NUM_CHN-1:0]            mask_q;
    logic [NUM_CHN-1:0]            pending;
    logic [NUM_CHN*DATA_WIDTH-1:0] fdb_snap;
    logic [NUM_CHN*DATA_WIDTH-1:0] ref_snap;

    logic                 tick;
    logic                 handshake;
    logic                 res_ok;
    logic [CHN_WIDTH-1:0] first_chn;
    logic [CHN_WIDTH-1:0] next_chn;
    logic                 next_found;
    logic [NUM_CHN-1:0]   pend_set;
    logic [NUM_CHN-1:0]   pend_clr;
    logic [NUM_CHN-1:0]   pend_nxt;

    assign tick      = en_i && (period_cnt == PW'(PERIOD - 1));
    assign handshake = data_valid_o && tready_i;
    assign res_ok    = res_valid_i && (int'(res_chn_i) < NUM_CHN) && (state != StIdle);
    assign pend_set  = handshake ? (NUM_CHN'(1) << data_chn_o) : '0;
    assign pend_clr  = res_ok ? (NUM_CHN'(1) << res_chn_i) : '0;
    assign pend_nxt  = (pending & ~pend_clr) | pend_set;

    // Descending scan so the lowest qualifying bit is the one left standing.
    always_comb begin
        first_chn  = '0;
        next_chn   = data_chn_o;
        next_found = 1'b0;
        for (int k = NUM_CHN - 1; k >= 0; k--) begin
            if (chn_mask_i[k]) first_chn = CHN_WIDTH'(k);
            if (mask_q[k] && (k > int'(data_chn_o))) begin
                next_found = 1'b1;
                next_chn   = CHN_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            period_cnt <= '0;
        end else if (!en_i || (period_cnt == PW'(PERIOD - 1))) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= StIdle;
            tmo_cnt       <= '0;
            mask_q        <= '0;
            pending       <= '0;
            fdb_snap      <= '0;
            ref_snap      <= '0;
            data_valid_o  <= 1'b0;
            data_chn_o    <= CHN_WIDTH'(NUM_CHN - 1);
            data_fdb_o    <= '0;
            data_ref_o    <= '0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            timeout_o     <= 1'b0;
            overrun_o     <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            timeout_o     <= 1'b0;
            pending       <= pend_nxt;
            if (tick && busy_o) begin
                overrun_o <= 1'b1;
            end else if (ovr_clr_i) begin
                overrun_o <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (tick && (chn_mask_i != '0)) begin
                        mask_q        <= chn_mask_i;
                        fdb_snap      <= fdb_bus_i;
                        ref_snap      <= ref_bus_i;
                        frame_start_o <= 1'b1;
                        data_valid_o  <= 1'b1;
                        data_chn_o    <= first_chn;
                        data_fdb_o    <= fdb_bus_i[int'(first_chn)*DATA_WIDTH +: DATA_WIDTH];
                        data_ref_o    <= ref_bus_i[int'(first_chn)*DATA_WIDTH +: DATA_WIDTH];
                        busy_o        <= 1'b1;
                        state         <= StIssue;
                    end
                end
                StIssue: begin
                    if (handshake) begin
                        if (next_found) begin
                            data_chn_o <= next_chn;
                            data_fdb_o <= fdb_snap[int'(next_chn)*DATA_WIDTH +: DATA_WIDTH];
                            data_ref_o <= ref_snap[int'(next_chn)*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            data_valid_o <= 1'b0;
                            tmo_cnt      <= '0;
                            state        <= StWait;
                        end
                    end
                end
                StWait: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    // A result landing on the timeout clock still completes the frame.
                    if (pend_nxt == '0) begin
                        frame_done_o <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= StIdle;
                    end else if (tmo_cnt == TW'(TIMEOUT)) begin
                        timeout_o <= 1'b1;
                        pending   <= '0;
                        busy_o    <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_chn_scheduler.sv
// Directed bench for pid_chn_scheduler with PERIOD=20, TIMEOUT=10 and a scripted PID-core
// responder that returns each accepted beat a fixed number of clocks later.
module tb_pid_chn_scheduler;

    localparam int DW  = 16;
    localparam int NC  = 4;
    localparam int CW  = 3;
    localparam int PER = 20;
    localparam int TO  = 10;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             en_i = 1'b0;
    logic [NC-1:0]    chn_mask_i = '0;
    logic             ovr_clr_i = 1'b0;
    logic [NC*DW-1:0] fdb_bus_i = '0;
    logic [NC*DW-1:0] ref_bus_i = '0;
    logic             data_valid_o;
    logic [CW-1:0]    data_chn_o;
    logic [DW-1:0]    data_fdb_o;
    logic [DW-1:0]    data_ref_o;
    logic             tready_i = 1'b0;
    logic             res_valid_i = 1'b0;
    logic [CW-1:0]    res_chn_i = '0;
    logic             frame_start_o;
    logic             frame_done_o;
    logic             timeout_o;
    logic             overrun_o;
    logic             busy_o;

    pid_chn_scheduler #(
        .DATA_WIDTH(DW),
        .NUM_CHN   (NC),
        .CHN_WIDTH (CW),
        .PERIOD    (PER),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en_i         (en_i),
        .chn_mask_i   (chn_mask_i),
        .ovr_clr_i    (ovr_clr_i),
        .fdb_bus_i    (fdb_bus_i),
        .ref_bus_i    (ref_bus_i),
        .data_valid_o (data_valid_o),
        .data_chn_o   (data_chn_o),
        .data_fdb_o   (data_fdb_o),
        .data_ref_o   (data_ref_o),
        .tready_i     (tready_i),
        .res_valid_i  (res_valid_i),
        .res_chn_i    (res_chn_i),
        .frame_start_o(frame_start_o),
        .frame_done_o (frame_done_o),
        .timeout_o    (timeout_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int fs_cyc = 0;

    // Responder state: beats accepted at a posedge are answered delay clocks later.
    int            cd[NC];
    bit            armed[NC];
    bit            hs_v = 1'b0;
    logic [CW-1:0] hs_chn = '0;
    int            delay = 3;
    logic [NC-1:0] withhold = '0;

    // Each call lands on the next falling edge: outputs are stable, inputs set here are
    // sampled at the following rising edge.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        res_valid_i = 1'b0;
        res_chn_i   = '0;
        for (int k = 0; k < NC; k++) if (armed[k] && cd[k] > 0) cd[k]--;
        for (int k = 0; k < NC; k++) begin
            if (armed[k] && cd[k] == 0 && !res_valid_i) begin
                res_valid_i = 1'b1;
                res_chn_i   = CW'(k);
                armed[k]    = 1'b0;
            end
        end
        if (hs_v && tready_i && rstn && !withhold[hs_chn]) begin
            armed[hs_chn] = 1'b1;
            cd[hs_chn]    = delay;
        end
        hs_v   = data_valid_o;
        hs_chn = data_chn_o;
    endtask

    task automatic clear_responder();
        for (int k = 0; k < NC; k++) begin
            armed[k] = 1'b0;
            cd[k]    = 0;
        end
        hs_v        = 1'b0;
        res_valid_i = 1'b0;
    endtask

    task automatic wait_fs(input int bound, output int n);
        n = 0;
        while (!frame_start_o && n < bound) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (frame_done_o || timeout_o) break;
            cyc();
        end
    endtask

    task automatic test_reset();
        logic [40:0] got;
        rstn = 1'b0;
        repeat (3) cyc();
        got = {data_valid_o, data_chn_o, data_fdb_o, data_ref_o,
               frame_start_o, frame_done_o, timeout_o, overrun_o, busy_o};
        vectors++;
        if (got !== {1'b0, 3'd3, 32'h0, 5'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", got, {1'b0, 3'd3, 32'h0, 5'b0});
        end
        rstn = 1'b1;
        repeat (3) cyc();
        vectors++;
        if (busy_o !== 1'b0 || frame_start_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_without_en: busy %b start %b expected 0 0", busy_o, frame_start_o);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ef[4];
        logic [15:0] er[4];
        int          n;
        ef = '{16'h1000, 16'h1111, 16'h1222, 16'h1333};
        er = '{16'h2000, 16'h2101, 16'h2202, 16'h2303};
        fdb_bus_i  = 64'h1333_1222_1111_1000;
        ref_bus_i  = 64'h2303_2202_2101_2000;
        chn_mask_i = 4'b1111;
        tready_i   = 1'b1;
        en_i       = 1'b1;
        wait_fs(40, n);
        vectors++;
        if (n !== 20) begin
            miscompares++;
            $display("FAIL first_tick_latency: got %0d clks expected 20", n);
        end
        fs_cyc = cyc_n;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({data_valid_o, data_chn_o, data_fdb_o, data_ref_o} !== {1'b1, CW'(k), ef[k], er[k]})
            begin
                miscompares++;
                $display("FAIL basic_beat%0d: got v=%b ch=%0d fdb=%h ref=%h expected 1 %0d %h %h",
                         k, data_valid_o, data_chn_o, data_fdb_o, data_ref_o, k, ef[k], er[k]);
            end
            if (k == 0) begin
                // Changes after the tick only matter to the next frame.
                fdb_bus_i  = 64'hA333_A222_A111_A000;
                ref_bus_i  = 64'hB303_B202_B101_B000;
                chn_mask_i = 4'b1010;
            end
            cyc();
        end
        vectors++;
        if (data_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_wait_entry: v=%b busy=%b expected 0 1", data_valid_o, busy_o);
        end
        wait_done(20);
        vectors++;
        if (frame_done_o !== 1'b1 || busy_o !== 1'b0 || cyc_n - fs_cyc != 8) begin
            miscompares++;
            $display("FAIL basic_done: done=%b busy=%b at +%0d expected 1 0 at +8",
                     frame_done_o, busy_o, cyc_n - fs_cyc);
        end
    endtask

    task automatic test_sparse();
        int n;
        wait_fs(40, n);
        vectors++;
        if (frame_start_o !== 1'b1 || cyc_n - fs_cyc != PER) begin
            miscompares++;
            $display("FAIL frame_period: got +%0d expected +%0d", cyc_n - fs_cyc, PER);
        end
        fs_cyc = cyc_n;
        vectors++;
        if ({data_valid_o, data_chn_o, data_fdb_o, data_ref_o} !== {1'b1, 3'd1, 16'hA111, 16'hB101})
        begin
            miscompares++;
            $display("FAIL sparse_beat_a: got v=%b ch=%0d fdb=%h ref=%h expected 1 1 a111 b101",
                     data_valid_o, data_chn_o, data_fdb_o, data_ref_o);
        end
        fdb_bus_i  = 64'hC333_C222_C111_C000;
        ref_bus_i  = 64'hD303_D202_D101_D000;
        chn_mask_i = 4'b1111;
        cyc();
        vectors++;
        if ({data_valid_o, data_chn_o, data_fdb_o, data_ref_o} !== {1'b1, 3'd3, 16'hA333, 16'hB303})
        begin
            miscompares++;
            $display("FAIL sparse_beat_b: got v=%b ch=%0d fdb=%h ref=%h expected 1 3 a333 b303",
                     data_valid_o, data_chn_o, data_fdb_o, data_ref_o);
        end
        cyc();
        vectors++;
        if (data_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL sparse_no_third_beat: v=%b expected 0", data_valid_o);
        end
        wait_done(20);
        vectors++;
        if (frame_done_o !== 1'b1 || cyc_n - fs_cyc != 6) begin
            miscompares++;
            $display("FAIL sparse_done: done=%b at +%0d expected 1 at +6",
                     frame_done_o, cyc_n - fs_cyc);
        end
    endtask

    task automatic test_backpressure();
        int n;
        wait_fs(40, n);
        fs_cyc = cyc_n;
        vectors++;
        if ({data_valid_o, data_chn_o, data_fdb_o} !== {1'b1, 3'd0, 16'hC000}) begin
            miscompares++;
            $display("FAIL bp_beat0: got v=%b ch=%0d fdb=%h expected 1 0 c000",
                     data_valid_o, data_chn_o, data_fdb_o);
        end
        cyc();
        tready_i = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            vectors++;
            if ({data_valid_o, data_chn_o, data_fdb_o, data_ref_o} !==
                {1'b1, 3'd1, 16'hC111, 16'hD101}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b ch=%0d fdb=%h ref=%h expected 1 1 c111 d101",
                         i, data_valid_o, data_chn_o, data_fdb_o, data_ref_o);
            end
            if (i == 5) tready_i = 1'b1;
            if (i < 5) cyc();
        end
        cyc();
        vectors++;
        if ({data_valid_o, data_chn_o, data_fdb_o} !== {1'b1, 3'd2, 16'hC222}) begin
            miscompares++;
            $display("FAIL bp_release: got v=%b ch=%0d fdb=%h expected 1 2 c222",
                     data_valid_o, data_chn_o, data_fdb_o);
        end
        cyc();
        wait_done(20);
        vectors++;
        if (frame_done_o !== 1'b1 || cyc_n - fs_cyc != 13) begin
            miscompares++;
            $display("FAIL bp_done: done=%b at +%0d expected 1 at +13",
                     frame_done_o, cyc_n - fs_cyc);
        end
    endtask

    task automatic test_timeout();
        int n;
        int dn = 0;
        int tn = 0;
        int tc = -1;
        withhold = 4'b0100;
        wait_fs(40, n);
        fs_cyc = cyc_n;
        // A stale ch2 pending bit would stall the two-channel frame that follows.
        chn_mask_i = 4'b0011;
        while (cyc_n - fs_cyc <= 16) begin
            if (frame_done_o) dn++;
            if (timeout_o) begin
                tn++;
                tc = cyc_n - fs_cyc;
            end
            cyc();
        end
        vectors++;
        if (tn != 1 || tc != 15 || dn != 0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got %0d pulses at +%0d done=%0d expected 1 at +15 done=0",
                     tn, tc, dn);
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_idle: busy=%b expected 0", busy_o);
        end
        withhold = '0;
        wait_fs(40, n);
        vectors++;
        if (frame_start_o !== 1'b1 || cyc_n - fs_cyc != PER) begin
            miscompares++;
            $display("FAIL timeout_next_tick: got +%0d expected +%0d", cyc_n - fs_cyc, PER);
        end
        fs_cyc = cyc_n;
        wait_done(30);
        vectors++;
        if (frame_done_o !== 1'b1 || cyc_n - fs_cyc != 6) begin
            miscompares++;
            $display("FAIL fresh_frame_done: done=%b to=%b at +%0d expected 1 0 at +6",
                     frame_done_o, timeout_o, cyc_n - fs_cyc);
        end
    endtask

    task automatic test_overrun();
        int n;
        chn_mask_i = 4'b1111;
        tready_i   = 1'b0;
        wait_fs(40, n);
        fs_cyc = cyc_n;
        while (cyc_n - fs_cyc < 20) cyc();
        vectors++;
        if ({overrun_o, frame_start_o, data_valid_o, data_chn_o} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL overrun_set: ovr=%b start=%b v=%b ch=%0d expected 1 0 1 0",
                     overrun_o, frame_start_o, data_valid_o, data_chn_o);
        end
        cyc();
        cyc();
        vectors++;
        if (overrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: ovr=%b expected 1", overrun_o);
        end
        ovr_clr_i = 1'b1;
        cyc();
        ovr_clr_i = 1'b0;
        vectors++;
        if (overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: ovr=%b expected 0", overrun_o);
        end
        while (cyc_n - fs_cyc < 39) cyc();
        vectors++;
        if (overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_before_tick: ovr=%b expected 0", overrun_o);
        end
        ovr_clr_i = 1'b1;
        cyc();
        ovr_clr_i = 1'b0;
        vectors++;
        if (overrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set_wins: ovr=%b expected 1", overrun_o);
        end
        tready_i = 1'b1;
        wait_done(30);
        vectors++;
        if (frame_done_o !== 1'b1 || overrun_o !== 1'b1 || cyc_n - fs_cyc != 48) begin
            miscompares++;
            $display("FAIL overrun_frame_done: done=%b ovr=%b at +%0d expected 1 1 at +48",
                     frame_done_o, overrun_o, cyc_n - fs_cyc);
        end
        ovr_clr_i = 1'b1;
        cyc();
        ovr_clr_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        int          n;
        logic [40:0] got;
        tready_i = 1'b0;
        wait_fs(45, n);
        cyc();
        cyc();
        vectors++;
        if (data_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_issue: v=%b busy=%b expected 1 1", data_valid_o, busy_o);
        end
        rstn = 1'b0;
        #1;
        got = {data_valid_o, data_chn_o, data_fdb_o, data_ref_o,
               frame_start_o, frame_done_o, timeout_o, overrun_o, busy_o};
        vectors++;
        if (got !== {1'b0, 3'd3, 32'h0, 5'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", got, {1'b0, 3'd3, 32'h0, 5'b0});
        end
        clear_responder();
        cyc();
        cyc();
        tready_i = 1'b1;
        rstn     = 1'b1;
        wait_fs(40, n);
        vectors++;
        if (n !== 20) begin
            miscompares++;
            $display("FAIL restart_latency: got %0d clks expected 20", n);
        end
        fs_cyc = cyc_n;
        wait_done(20);
        vectors++;
        if (frame_done_o !== 1'b1 || cyc_n - fs_cyc != 8) begin
            miscompares++;
            $display("FAIL restart_done: done=%b at +%0d expected 1 at +8",
                     frame_done_o, cyc_n - fs_cyc);
        end
    endtask

    task automatic test_zero_mask();
        int starts = 0;
        int busies = 0;
        chn_mask_i = '0;
        repeat (30) begin
            cyc();
            if (frame_start_o) starts++;
            if (busy_o) busies++;
        end
        vectors++;
        if (starts != 0 || busies != 0) begin
            miscompares++;
            $display("FAIL zero_mask_ignored: starts=%0d busy_clks=%0d expected 0 0", starts, busies);
        end
    endtask

    initial begin
        clear_responder();
        test_reset();
        test_basic();
        test_sparse();
        test_backpressure();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_zero_mask();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pid_chn_scheduler.md
# pid_chn_scheduler

Frame-based scheduler for the shared, time-multiplexed PID core. Every PERIOD clocks it snapshots the per-channel feedback and reference words, then issues one beat per enabled channel over the core's valid/ready data port. It tracks each channel's result until all have returned, and flags overruns and lost results. It replaces the free-running channel counter in front of the PID core with a deterministic control-loop sample rate.

## Interface
- DATA_WIDTH, 16, width of feedback/reference words
- NUM_CHN, 4, number of PID channels (1..7)
- CHN_WIDTH, 3, channel index width
- PERIOD, 50000, clocks per control frame (≥ NUM_CHN+4)
- TIMEOUT, 255, max clocks in WAIT before abort (≥1)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- en_i  in  1  scheduler enable
- chn_mask_i  in  NUM_CHN  per-channel enable, bit k = channel k
- ovr_clr_i  in  1  clears sticky overrun_o
- fdb_bus_i  in  NUM_CHN*DATA_WIDTH  measured rpm; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- ref_bus_i  in  NUM_CHN*DATA_WIDTH  target rpm; same packing
- data_valid_o  out  1  beat valid to PID core
- data_chn_o  out  CHN_WIDTH  beat channel
- data_fdb_o / data_ref_o  out  DATA_WIDTH each  beat payload
- tready_i  in  1  PID core accepts beat
- res_valid_i  in  1  PID core result strobe
- res_chn_i  in  CHN_WIDTH  result channel
- frame_start_o  out  1  1-clk pulse, frame accepted
- frame_done_o  out  1  1-clk pulse, all results returned
- timeout_o  out  1  1-clk pulse, frame aborted
- overrun_o  out  1  sticky, tick arrived while busy
- busy_o  out  1  FSM not IDLE

## Operation
- Period counter: 0..PERIOD-1, wraps; held at 0 while en_i=0. Tick = en_i & counter==PERIOD-1.
- FSM IDLE → ISSUE → WAIT → IDLE.
- IDLE, tick, chn_mask_i≠0: latch mask, snapshot all fdb/ref words, pulse frame_start_o, enter ISSUE at lowest set mask bit. Tick with mask=0: ignored, no pulses.
- ISSUE: present latched channel's snapshot with data_valid_o=1; payload and channel held stable until tready_i=1. On handshake set pending[chn], advance to next higher latched mask bit; after last bit enter WAIT.
- WAIT: timeout counter increments each clock from 0. pending==0 → pulse frame_done_o, IDLE. Counter reaches TIMEOUT with pending≠0 → pulse timeout_o, clear pending, IDLE.
- res_valid_i in ISSUE or WAIT clears pending[res_chn_i]; results for non-pending or out-of-range channels are ignored. Set and clear of different channels in the same clock both take effect.
- Tick while busy_o=1: tick dropped, overrun_o set. ovr_clr_i clears it; simultaneous set and clear → set wins.
- en_i deasserted mid-frame: current frame runs to done/timeout; no further ticks.
- chn_mask_i and bus changes mid-frame have no effect until the next accepted tick.
- Reset: FSM IDLE, all counters 0, pending 0; all outputs 0 except data_chn_o = NUM_CHN-1.

## Timing
- All outputs registered.
- Tick sampled at clock T. frame_start_o and first data_valid_o are high in T+1.
- Back-to-back beats with tready_i=1: one channel per clock. Next valid beat appears the clock after the handshake.
- Last handshake at clock H: WAIT from H+1.
- Final pending clear at clock R: frame_done_o high at R+1, busy_o low at R+1.
- Timeout: timeout_o high TIMEOUT+1 clocks after WAIT entry.
- First tick: PERIOD-1 clocks after en_i rises.

## Test plan
- Basic frame: PERIOD=20, mask=4'b1111, tready_i=1, results 3 clks after each issue → beats ch0..ch3 with snapshot values on T+1..T+4; frame_done_o one clk after ch3 result; next tick 20 clks after the first.
- Sparse mask: mask=4'b1010 → exactly two beats, ch1 then ch3 on consecutive clks; ch0/ch2 never issued.
- Backpressure: tready_i low for 5 clks on the ch1 beat → data_chn_o=1 and payload stable throughout; ch2 appears the clk after tready_i rises.
- Timeout: withhold the ch2 result, TIMEOUT=10 → timeout_o pulses once, no frame_done_o, busy_o low; next tick starts a fresh frame.
- Overrun: results delayed past PERIOD → overrun_o set and held; tick dropped. ovr_clr_i pulse clears it; ovr_clr_i coincident with a new overrun → stays 1.
- Reset mid-ISSUE with data_valid_o=1 → all outputs at reset values immediately; restart requires a full PERIOD after rstn release.
